sym_buf_ctrl: RTL and testbench



---
 rtl/sbc_pkg.sv | 16 +
 rtl/sbc_addr_gen.sv | 21 ++
 rtl/sym_buf_ctrl.sv | 149 ++++++++++++++
 tb/tb_sym_buf_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbc_pkg.sv
// Shared types and constants for the RX symbol buffer sequencer (sym_buf_ctrl).
// The SBC_REVERSE_EN build macro is consumed only by sbc_addr_gen.
package sbc_pkg;

    localparam int SBC_DEPTH = 14;
    localparam int SBC_DW    = 16;
    localparam int SBC_AW    = 4;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } sbc_state_e;

    typedef logic signed [SBC_DW-1:0] sbc_sample_t;

endpackage

// File: rtl/sbc_addr_gen.sv
// Read address mapping for the symbol buffer: natural order by default,
// reversed (DEPTH-1 down to 0) when built with SBC_REVERSE_EN defined.
module sbc_addr_gen
    import sbc_pkg::*;
#(
    parameter int DEPTH = SBC_DEPTH,
    parameter int AW    = SBC_AW
) (
    input  logic [AW-1:0] i_rdCnt,
    output logic [AW-1:0] o_rdAddr
);

`ifdef SBC_REVERSE_EN
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    assign o_rdAddr = LAST - i_rdCnt;
`else
    assign o_rdAddr = i_rdCnt;
`endif

endmodule

// File: rtl/sym_buf_ctrl.sv
// Fill/drain sequencer for the real/imag symbol RAM pair; optional reversed
// read order is selected with the SBC_REVERSE_EN macro (see sbc_addr_gen).
module sym_buf_ctrl
    import sbc_pkg::*;
#(
    parameter int DEPTH = SBC_DEPTH,
    parameter int DW    = SBC_DW,
    parameter int AW    = SBC_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di_re,
    output logic [DW-1:0] ram_di_im,
    input  logic [DW-1:0] ram_do_re,
    input  logic [DW-1:0] ram_do_im,
    output logic          frame_done
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    sbc_state_e    r_state;
    sbc_state_e    w_stateNext;
    logic [AW-1:0] r_wrCnt;
    logic [AW-1:0] w_wrCntNext;
    logic [AW-1:0] r_rdCnt;
    logic [AW-1:0] w_rdCntNext;
    logic          r_rdDone;
    logic          w_rdDoneNext;
    logic          r_outValid;
    logic          w_outValidNext;
    logic          w_rdIssue;
    logic [AW-1:0] w_rdAddr;

    sbc_addr_gen #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_addrGen (
        .i_rdCnt  (r_rdCnt),
        .o_rdAddr (w_rdAddr)
    );

    assign out_valid = r_outValid;
    assign out_re    = ram_do_re;
    assign out_im    = ram_do_im;
    assign ram_di_re = in_re;
    assign ram_di_im = in_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_wrCnt    <= '0;
            r_rdCnt    <= '0;
            r_rdDone   <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_wrCnt    <= w_wrCntNext;
            r_rdCnt    <= w_rdCntNext;
            r_rdDone   <= w_rdDoneNext;
            r_outValid <= w_outValidNext;
        end
    end

    // r_rdDone marks that all DEPTH reads are issued, so rd_cnt can stay within 0..DEPTH-1.
    always_comb begin
        w_stateNext    = r_state;
        w_wrCntNext    = r_wrCnt;
        w_rdCntNext    = r_rdCnt;
        w_rdDoneNext   = r_rdDone;
        w_outValidNext = r_outValid;
        w_rdIssue      = 1'b0;
        in_ready       = 1'b0;
        ram_en         = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = '0;
        frame_done     = 1'b0;

        case (r_state)
            FILL: begin
                in_ready       = 1'b1;
                w_outValidNext = 1'b0;
                if (in_valid) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = r_wrCnt;
                    if (r_wrCnt == LAST) begin
                        w_wrCntNext = '0;
                        w_stateNext = DRAIN;
                    end else begin
                        w_wrCntNext = r_wrCnt + 1'b1;
                    end
                end
            end

            DRAIN: begin
                w_rdIssue = !r_rdDone && (!r_outValid || out_ready);
                if (w_rdIssue) begin
                    ram_en         = 1'b1;
                    ram_addr       = w_rdAddr;
                    w_outValidNext = 1'b1;
                    if (r_rdCnt == LAST) begin
                        w_rdDoneNext = 1'b1;
                    end else begin
                        w_rdCntNext = r_rdCnt + 1'b1;
                    end
                end else if (out_ready) begin
                    w_outValidNext = 1'b0;
                end

                if (r_outValid && out_ready && r_rdDone) begin
                    frame_done   = 1'b1;
                    w_rdCntNext  = '0;
                    w_rdDoneNext = 1'b0;
                    w_stateNext  = FILL;
                end
            end

            default: begin
                w_stateNext = FILL;
            end
        endcase

        // Flush overrides everything above: no RAM access, no completion pulse.
        if (flush) begin
            w_stateNext    = FILL;
            w_wrCntNext    = '0;
            w_rdCntNext    = '0;
            w_rdDoneNext   = 1'b0;
            w_outValidNext = 1'b0;
            ram_en         = 1'b0;
            ram_we         = 1'b0;
            ram_addr       = '0;
            frame_done     = 1'b0;
        end
    end

endmodule

// File: tb/tb_sym_buf_ctrl.sv
// Self-checking bench for sym_buf_ctrl with a behavioural RAM pair and a
// queue-based frame model; build with SBC_REVERSE_EN to check reversed order.
module tb_sym_buf_ctrl;

    localparam int DEPTH = 14;
    localparam int DW    = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di_re;
    logic [DW-1:0] ram_di_im;
    logic [DW-1:0] ram_do_re;
    logic [DW-1:0] ram_do_im;
    logic          frame_done;

    sym_buf_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_di_re  (ram_di_re),
        .ram_di_im  (ram_di_im),
        .ram_do_re  (ram_do_re),
        .ram_do_im  (ram_do_im),
        .frame_done (frame_done)
    );

    logic [DW-1:0] memRe [16];
    logic [DW-1:0] memIm [16];

    // Single-port RAM pair with registered read data; dout holds when not enabled.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                memRe[ram_addr] <= ram_di_re;
                memIm[ram_addr] <= ram_di_im;
            end else begin
                ram_do_re <= memRe[ram_addr];
                ram_do_im <= memIm[ram_addr];
            end
        end
    end

    int            checkCount = 0;
    int            failCount  = 0;
    int            cycleCnt   = 0;
    int            readyMode  = 0;
    int            readyPhase = 0;
    int            outCount   = 0;
    int            outTotal   = 0;
    bit            monEn      = 0;
    bit            prevStall  = 0;
    bit            prevDone   = 0;
    logic [DW-1:0] prevRe;
    logic [DW-1:0] prevIm;
    logic [DW-1:0] wrRe [$];
    logic [DW-1:0] wrIm [$];
    logic [31:0]   expQ [$];
    int            doneCycles [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cycleCnt++;
    end

    // Downstream readiness: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1: begin
                    out_ready  = (readyPhase == 0) || (readyPhase == 3);
                    readyPhase = (readyPhase + 1) % 4;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Every comparison goes through here; mismatches increment failCount.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, observed, expected, cycleCnt);
        end
    endtask

    // A completed frame enters the expected-output queue in the configured read order.
    task automatic recordSample(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int idx;
        wrRe.push_back(re);
        wrIm.push_back(im);
        if (wrRe.size() == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef SBC_REVERSE_EN
                idx = DEPTH - 1 - i;
`else
                idx = i;
`endif
                expQ.push_back({wrRe[idx], wrIm[idx]});
            end
            wrRe.delete();
            wrIm.delete();
        end
    endtask

    // Per-cycle observation of the output side, sampled on the falling edge.
    task automatic monitorStep();
        bit          hs;
        logic [31:0] s;
        if (!monEn || !rst_n) begin
            prevStall = 0;
            prevDone  = 0;
            return;
        end
        hs = out_valid && out_ready && !flush;
        if (prevDone && !flush)
            checkOutput("in_ready_after_done", 16'(in_ready), 16'd1);
        checkOutput("frame_done", 16'(frame_done), 16'(hs && (outCount == DEPTH - 1)));
        prevDone = frame_done;
        if (frame_done)
            doneCycles.push_back(cycleCnt);
        if (hs) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_output", 16'd1, 16'd0);
            end else begin
                s = expQ.pop_front();
                checkOutput("out_re", out_re, s[31:16]);
                checkOutput("out_im", out_im, s[15:0]);
            end
            outCount = (outCount == DEPTH - 1) ? 0 : outCount + 1;
            outTotal++;
        end
        if (out_valid && !out_ready) begin
            checkOutput("stall_ram_en", 16'(ram_en), 16'd0);
            if (prevStall) begin
                checkOutput("stall_re_stable", out_re, prevRe);
                checkOutput("stall_im_stable", out_im, prevIm);
            end
            prevStall = 1;
            prevRe    = out_re;
            prevIm    = out_im;
        end else begin
            prevStall = 0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitorStep();
    end

    // Offer n samples (base+k / -(base+k), or random), with optional random valid gaps.
    task automatic applyStimulus(input int base, input int n, input bit randData,
                                 input bit gaps, input bit holdValid);
        int            k     = 0;
        int            guard = 0;
        bit            needNew = 1;
        logic [DW-1:0] curRe = '0;
        logic [DW-1:0] curIm = '0;
        while (k < n && guard < 3000) begin
            @(posedge clk);
            #1;
            if (needNew) begin
                curRe   = randData ? DW'($urandom) : DW'(base + k);
                curIm   = randData ? DW'($urandom) : DW'(-(base + k));
                needNew = 0;
            end
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_re    = curRe;
            in_im    = curIm;
            @(negedge clk);
            if (in_valid && in_ready) begin
                recordSample(curRe, curIm);
                k++;
                needNew = 1;
            end
            guard++;
        end
        if (k < n)
            checkOutput("fill_timeout", 16'd0, 16'd1);
        if (!holdValid) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drainWait();
        int guard = 0;
        while ((expQ.size() != 0 || out_valid) && guard < 3000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        checkOutput("drain_complete", 16'(expQ.size()), 16'd0);
    endtask

    int doneBefore;
    int outBase;
    int guardCnt;

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 16'(in_ready), 16'd1);
        checkOutput("reset_out_valid", 16'(out_valid), 16'd0);
        checkOutput("reset_frame_done", 16'(frame_done), 16'd0);
        checkOutput("reset_ram_en", 16'(ram_en), 16'd0);
        rst_n = 1'b1;
        monEn = 1;

        $display("[TB] basic frame re=k im=-k");
        readyMode = 0;
        doneBefore = doneCycles.size();
        applyStimulus(0, DEPTH, 0, 0, 0);
        drainWait();
        checkOutput("basic_done_count", 16'(doneCycles.size() - doneBefore), 16'd1);

        $display("[TB] backpressure 1,0,0,1");
        readyMode  = 1;
        readyPhase = 0;
        applyStimulus(30, DEPTH, 0, 0, 0);
        drainWait();

        $display("[TB] back-to-back frames");
        readyMode = 0;
        doneBefore = doneCycles.size();
        applyStimulus(0, DEPTH, 0, 0, 1);
        applyStimulus(100, DEPTH, 0, 0, 0);
        drainWait();
        checkOutput("b2b_done_count", 16'(doneCycles.size() - doneBefore), 16'd2);
        if (doneCycles.size() - doneBefore == 2)
            checkOutput("frame_period", 16'(doneCycles[doneBefore+1] - doneCycles[doneBefore]), 16'd29);

        $display("[TB] flush after 7 writes");
        doneBefore = doneCycles.size();
        applyStimulus(200, 7, 0, 0, 0);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_re    = 16'h0999;
        @(negedge clk);
        checkOutput("flush_ram_en", 16'(ram_en), 16'd0);
        wrRe.delete();
        wrIm.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        applyStimulus(50, DEPTH, 0, 0, 0);
        drainWait();
        checkOutput("flush_done_count", 16'(doneCycles.size() - doneBefore), 16'd1);

        $display("[TB] reset mid-drain");
        outBase = outTotal;
        applyStimulus(20, DEPTH, 0, 0, 0);
        guardCnt = 0;
        while (outTotal - outBase < 5 && guardCnt < 200) begin
            @(posedge clk);
            #2;
            guardCnt++;
        end
        checkOutput("reset_wait_outputs", 16'(outTotal - outBase), 16'd5);
        monEn = 0;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 16'(out_valid), 16'd0);
        checkOutput("midreset_frame_done", 16'(frame_done), 16'd0);
        expQ.delete();
        wrRe.delete();
        wrIm.delete();
        outCount = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("postreset_in_ready", 16'(in_ready), 16'd1);
        monEn = 1;
        doneBefore = doneCycles.size();
        applyStimulus(70, DEPTH, 0, 0, 0);
        drainWait();
        checkOutput("postreset_done_count", 16'(doneCycles.size() - doneBefore), 16'd1);

        $display("[TB] random data, gaps and backpressure");
        readyMode = 2;
        doneBefore = doneCycles.size();
        for (int f = 0; f < 3; f++)
            applyStimulus(0, DEPTH, 1, 1, 0);
        drainWait();
        checkOutput("random_done_count", 16'(doneCycles.size() - doneBefore), 16'd3);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
